// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default operand widths and the divider FSM encoding.
package arith_pkg;

  localparam int unsigned DEF_WIDTH_N = 8;
  localparam int unsigned DEF_WIDTH_D = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } div_state_t;

endpackage : arith_pkg

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift in one dividend bit, trial-subtract
// the divisor, keep the difference if it is non-negative, otherwise restore.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] div,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_in < div always holds, so shifted < 2*div and fits in W+1 bits;
  // bit W of the difference is therefore a reliable borrow/sign indicator.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, div};
    q_bit   = ~diff[W];
    rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule : div_step

// File: rtl/rdx2_seq_div.sv
// Sequential restoring radix-2 divider, signed or unsigned, one quotient bit per clock.
module rdx2_seq_div
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH_N = DEF_WIDTH_N,
  parameter int unsigned WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               vld_in,
  input  logic               sgn,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               busy,
  output logic               done,
  output logic               dz
);

  localparam int unsigned CNT_W = $clog2(WIDTH_N + 1);

  div_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH_N-1:0] quo;
  logic [WIDTH_D-1:0] rem;
  logic [WIDTH_D-1:0] dvs;
  logic [WIDTH_D-1:0] rem_step;
  logic               q_bit;
  logic               q_neg;
  logic               r_neg;
  logic               dz_r;

  logic               accept;
  logic               last_step;
  logic               dvd_neg;
  logic               dvs_neg;
  logic               dvs_zero;
  logic [WIDTH_N-1:0] dvd_mag;
  logic [WIDTH_D-1:0] dvs_mag;

  assign accept    = (state == S_IDLE) && vld_in;
  assign last_step = (cnt == CNT_W'(WIDTH_N - 1));
  assign dvd_neg   = sgn & dividend[WIDTH_N-1];
  assign dvs_neg   = sgn & divisor[WIDTH_D-1];
  assign dvs_zero  = (divisor == '0);
  assign dvd_mag   = dvd_neg ? -dividend : dividend;
  assign dvs_mag   = dvs_neg ? -divisor : divisor;
  assign busy      = (state != S_IDLE);

  div_step #(
    .W (WIDTH_D)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (quo[WIDTH_N-1]),
    .div     (dvs),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a zero divisor bypasses the iteration entirely.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (vld_in) state_nxt = dvs_zero ? S_FIX : S_CALC;
      S_CALC: if (last_step) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration and result write-back.
  // For divide-by-zero the raw dividend is parked in quo so FIX can return
  // its low bits as the remainder without an extra register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz_r      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            dvs   <= dvs_mag;
            q_neg <= dvd_neg ^ dvs_neg;
            r_neg <= dvd_neg;
            dz_r  <= dvs_zero;
            quo   <= dvs_zero ? dividend : dvd_mag;
          end
        end
        S_CALC: begin
          quo <= {quo[WIDTH_N-2:0], q_bit};
          rem <= rem_step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          done <= 1'b1;
          dz   <= dz_r;
          if (dz_r) begin
            quotient  <= '1;
            remainder <= quo[WIDTH_D-1:0];
          end else begin
            quotient  <= q_neg ? -quo : quo;
            remainder <= r_neg ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : rdx2_seq_div

// File: tb/tb_rdx2_seq_div.sv
// Directed bench for rdx2_seq_div at 8/8 bit widths.
module tb_rdx2_seq_div;

  logic       clk;
  logic       rstn;
  logic       vld_in;
  logic       sgn;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       dz;

  int tests;
  int fails;
  int lat;

  rdx2_seq_div #(
    .WIDTH_N (8),
    .WIDTH_D (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .vld_in    (vld_in),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until done is seen 1 ns after an edge (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  // Presents one operation; returns edges from accept edge 0 to the done edge.
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output int n);
    @(negedge clk);
    vld_in = 1'b1; sgn = s; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    wait_done(n);
  endtask

  initial begin
    tests = 0; fails = 0;
    rstn = 1'b0; vld_in = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {13'd0, quotient, remainder, busy, done, dz}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 200/7 unsigned, with latency, busy and hold checks
    @(negedge clk);
    vld_in = 1'b1; sgn = 1'b0; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("u200_7_latency", lat, 9);
    chk("u200_7_result", {15'd0, quotient, remainder, dz}, {15'd0, 8'd28, 8'd4, 1'b0});
    chk("busy_in_done_cycle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("result_hold", {16'd0, quotient, remainder}, {16'd0, 8'd28, 8'd4});

    run_op(1'b1, 8'h9C, 8'd7, lat);
    chk("s_m100_7", {15'd0, quotient, remainder, dz}, {15'd0, 8'hF2, 8'hFE, 1'b0});

    run_op(1'b1, 8'h64, 8'hF9, lat);
    chk("s_100_m7", {15'd0, quotient, remainder, dz}, {15'd0, 8'hF2, 8'h02, 1'b0});

    run_op(1'b1, 8'h80, 8'hFF, lat);
    chk("s_min_m1", {15'd0, quotient, remainder, dz}, {15'd0, 8'h80, 8'h00, 1'b0});

    run_op(1'b0, 8'hFF, 8'h01, lat);
    chk("u255_1", {15'd0, quotient, remainder, dz}, {15'd0, 8'hFF, 8'h00, 1'b0});

    run_op(1'b0, 8'd55, 8'd0, lat);
    chk("dz_latency", lat, 1);
    chk("u55_0", {15'd0, quotient, remainder, dz}, {15'd0, 8'hFF, 8'd55, 1'b1});

    run_op(1'b0, 8'd13, 8'd13, lat);
    chk("u13_13_dz_clear", {15'd0, quotient, remainder, dz}, {15'd0, 8'd1, 8'd0, 1'b0});

    // 9/2 request during CALC must be ignored
    @(negedge clk);
    vld_in = 1'b1; sgn = 1'b0; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld_in = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    wait_done(lat);
    chk("ignore_latency", lat, 7);
    chk("ignore_result", {16'd0, quotient, remainder}, {16'd0, 8'd28, 8'd4});

    // reset asserted before edge 4 aborts the operation
    @(negedge clk);
    vld_in = 1'b1; sgn = 1'b0; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_outputs", {13'd0, quotient, remainder, busy, done, dz}, 32'd0);
    lat = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) lat++;
    end
    chk("abort_no_done", lat, 0);
    @(negedge clk);
    rstn = 1'b1;

    run_op(1'b0, 8'd9, 8'd2, lat);
    chk("post_reset_latency", lat, 9);
    chk("post_reset_9_2", {15'd0, quotient, remainder, dz}, {15'd0, 8'd4, 8'd1, 1'b0});

    // back-to-back: vld_in held through the done cycle
    @(negedge clk);
    vld_in = 1'b1; sgn = 1'b0; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("b2b_first_latency", lat, 9);
    chk("b2b_first", {16'd0, quotient, remainder}, {16'd0, 8'd28, 8'd4});
    dividend = 8'd9; divisor = 8'd2;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    chk("b2b_accepted", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("b2b_gap", lat + 1, 10);
    chk("b2b_second", {16'd0, quotient, remainder}, {16'd0, 8'd4, 8'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rdx2_seq_div

// File: doc/rdx2_seq_div.md
RDX2_SEQ_DIV -- requirements
Module: rdx2_seq_div

Interface
REQ-001 The block SHALL have parameter WIDTH_N, default 8, the dividend and quotient width.
REQ-002 The block SHALL have parameter WIDTH_D, default 8, the divisor and remainder width, with WIDTH_D <= WIDTH_N.
REQ-003 clk  input  1  clock, all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 vld_in  input  1  start request; operands and sgn sampled with it.
REQ-006 sgn  input  1  1 = two's-complement signed operation, 0 = unsigned.
REQ-007 dividend  input  WIDTH_N  numerator.
REQ-008 divisor  input  WIDTH_D  denominator.
REQ-009 quotient  output  WIDTH_N  registered quotient.
REQ-010 remainder  output  WIDTH_D  registered remainder.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse; quotient, remainder and dz are valid when it is high.
REQ-013 dz  output  1  divide-by-zero flag, valid with done.

Function
REQ-014 FSM states SHALL be IDLE, CALC and FIX.
REQ-015 In IDLE, a rising edge with vld_in=1 SHALL latch operand magnitudes and result signs, clear the step counter, set busy=1 and enter CALC.
REQ-016 If the latched divisor is zero, the FSM SHALL go from IDLE directly to FIX, skipping CALC.
REQ-017 vld_in SHALL be ignored while busy=1.
REQ-018 CALC SHALL be a restoring radix-2 step, one quotient bit per edge, MSB first, for exactly WIDTH_N edges.
REQ-019 After the last CALC step, the FSM SHALL enter FIX.
REQ-020 FIX SHALL write quotient, remainder and dz, pulse done=1, clear busy and return to IDLE in one edge.
REQ-021 Latency: done SHALL be high in the cycle that follows edge WIDTH_N+1, counting the accept edge as edge 0; for dz, done SHALL follow edge 1.
REQ-022 A vld_in that is high in the done cycle SHALL be accepted, because the FSM is in IDLE.
REQ-023 Signed operation: quotient SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign (zero remainder is 0).
REQ-024 Signed minimum divided by -1 SHALL produce quotient = minimum (wrap), remainder = 0 and dz = 0.
REQ-025 For divide by zero, quotient SHALL be all ones, remainder SHALL be dividend[WIDTH_D-1:0] and dz SHALL be 1.
REQ-026 quotient, remainder and dz SHALL hold their values until the next FIX.

Reset
REQ-027 While rstn=0, the FSM SHALL be in IDLE and all outputs SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation, with no done pulse.
REQ-029 The first vld_in after reset release SHALL be processed normally.

Structure
REQ-030 The FSM state encoding and the default widths SHALL be defined in the shared package arith_pkg.
REQ-031 One combinational sub-module, div_step, SHALL perform a single shift/trial-subtract/restore and return the next partial remainder and the quotient bit.

Verification (WIDTH_N = WIDTH_D = 8)
REQ-032 Unsigned 200/7 -> quotient 28, remainder 4, dz 0; done exactly after edge 9, busy high for edges 0-8.
REQ-033 Signed -100/7 -> quotient 0xF2, remainder 0xFE; signed 100/-7 -> quotient 0xF2, remainder 0x02.
REQ-034 Signed 0x80 / 0xFF -> quotient 0x80, remainder 0x00, dz 0.
REQ-035 55/0 -> quotient 0xFF, remainder 55, dz 1; done after edge 1.
REQ-036 vld_in with 9/2 pulsed mid-CALC of 200/7 -> ignored, result is 28 r 4; rstn low at edge 4 -> outputs 0 and no done; after release 9/2 -> 4 r 1.
REQ-037 Back-to-back: vld_in held high through the done cycle -> the second operation completes 10 cycles after the first done.
